// File: rtl/ascii_hex_parser_pkg.sv
// Shared types and character constants for the ASCII hex token parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascii_hex_parser_pkg;

    typedef logic [7:0] data_uart_t;

    localparam data_uart_t KEY_0     = 8'd48;
    localparam data_uart_t KEY_9     = 8'd57;
    localparam data_uart_t KEY_A     = 8'd65;
    localparam data_uart_t KEY_F     = 8'd70;
    localparam data_uart_t KEY_a     = 8'd97;
    localparam data_uart_t KEY_f     = 8'd102;
    localparam data_uart_t KEY_SEP   = 8'd95;
    localparam data_uart_t KEY_CR    = 8'd13;
    localparam data_uart_t KEY_SPACE = 8'd32;

    typedef enum logic {
        ACCUM = 1'b0,
        SKIP  = 1'b1
    } parser_state_e;

endpackage

// File: rtl/ascii_hex_parser_if.sv
// Byte-in / token-out stream bundle for the ASCII hex parser.
// Latency: n/a (wires only). Ports: in_* byte stream, out_* token stream, frame_done/err pulses.
// Backpressure: in_ready from the parser, out_ready from the token consumer.
interface ascii_hex_parser_if
    import ascii_hex_parser_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) ();

    data_uart_t          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;
    logic                frame_done;
    logic                err;

    // Parser side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_last, out_valid, frame_done, err
    );

    // Byte source / token sink side.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_last, out_valid, frame_done, err
    );

endinterface

// File: rtl/ascii_hex_parser_classify.sv
// ASCII character classifier: digit/separator/terminator/space flags plus hex nibble.
// Latency: combinational. Ports: chr in; is_digit, is_sep, is_term, is_space, nibble out.
// Backpressure: none.
module ascii_classify
    import ascii_hex_parser_pkg::*;
(
    input  data_uart_t  chr,
    output logic        is_digit,
    output logic        is_sep,
    output logic        is_term,
    output logic        is_space,
    output logic [3:0]  nibble
);

    always_comb begin
        is_digit = 1'b0;
        nibble   = 4'd0;
        if (chr >= KEY_0 && chr <= KEY_9) begin
            is_digit = 1'b1;
            nibble   = 4'(chr - KEY_0);
        end else if (chr >= KEY_A && chr <= KEY_F) begin
            is_digit = 1'b1;
            nibble   = 4'(chr - KEY_A + 8'd10);
        end else if (chr >= KEY_a && chr <= KEY_f) begin
            is_digit = 1'b1;
            nibble   = 4'(chr - KEY_a + 8'd10);
        end
    end

    assign is_sep   = (chr == KEY_SEP);
    assign is_term  = (chr == KEY_CR);
    assign is_space = (chr == KEY_SPACE);

endmodule

// File: rtl/ascii_hex_parser.sv
// Assembles multi-digit ASCII hex tokens into DATA_W-bit values tagged with a frame index.
// Latency: token visible one cycle after its closing byte is accepted; err/frame_done pulse in that same cycle.
// Backpressure: one-entry output buffer; in_ready drops while the buffer is full (no bypass).
module ascii_hex_parser
    import ascii_hex_parser_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAX_DIGITS = DATA_W / 4,
    parameter int IDX_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    ascii_hex_parser_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    parser_state_e       state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic                frame_done_q, frame_done_d;
    // Holds in_ready low during reset and for the first edge after release.
    logic                rdy_en_q, rdy_en_d;

    logic                is_digit, is_sep, is_term, is_space;
    logic [3:0]          nibble;
    logic                accept;
    logic                is_other;
    logic                cnt_full;

    ascii_classify u_classify (
        .chr      (bus.in_data),
        .is_digit (is_digit),
        .is_sep   (is_sep),
        .is_term  (is_term),
        .is_space (is_space),
        .nibble   (nibble)
    );

    assign bus.in_ready = rdy_en_q & ~out_valid_q;
    assign accept       = bus.in_valid & bus.in_ready;
    assign is_other     = ~(is_digit | is_sep | is_term | is_space);
    assign cnt_full     = (digit_cnt_q == CNT_W'(MAX_DIGITS));
    assign rdy_en_d     = 1'b1;

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            digit_cnt_q  <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            digit_cnt_q  <= digit_cnt_d;
            idx_q        <= idx_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            rdy_en_q     <= rdy_en_d;
        end
    end

    // Next state: any error drops into SKIP until a token boundary.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ACCUM: if ((is_digit && cnt_full) || is_other) state_d = SKIP;
                SKIP:  if (is_sep || is_term)                  state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Accumulator, index counter, output buffer and pulses.
    always_comb begin
        acc_d        = acc_q;
        digit_cnt_d  = digit_cnt_q;
        idx_d        = idx_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q & ~bus.out_ready;
        err_d        = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            if (state_q == ACCUM) begin
                if (is_digit) begin
                    if (!cnt_full) begin
                        acc_d       = (acc_q << 4) | DATA_W'(nibble);
                        digit_cnt_d = digit_cnt_q + CNT_W'(1);
                    end else begin
                        err_d       = 1'b1;
                        acc_d       = '0;
                        digit_cnt_d = '0;
                    end
                end else if (is_sep) begin
                    if (digit_cnt_q != '0) begin
                        out_data_d  = acc_q;
                        out_idx_d   = idx_q;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b1;
                        idx_d       = idx_q + IDX_W'(1);
                        acc_d       = '0;
                        digit_cnt_d = '0;
                    end
                end else if (is_term) begin
                    if (digit_cnt_q != '0) begin
                        out_data_d  = acc_q;
                        out_idx_d   = idx_q;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                    end
                    frame_done_d = 1'b1;
                    idx_d        = '0;
                    acc_d        = '0;
                    digit_cnt_d  = '0;
                end else if (is_other) begin
                    err_d       = 1'b1;
                    acc_d       = '0;
                    digit_cnt_d = '0;
                end
            end else if (is_term) begin
                // A terminator still closes the frame even while skipping.
                frame_done_d = 1'b1;
                idx_d        = '0;
            end
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.err        = err_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
module tb_ascii_hex_parser;

    localparam int DATA_W = 8;
    localparam int MAXD   = 2;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ascii_hex_parser_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    ascii_hex_parser #(.DATA_W(DATA_W), .MAX_DIGITS(MAXD), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit rdy_rand = 1'b0;

    // Reference model: token text is collected as a number and a digit count;
    // a "bad" flag swallows characters until the next boundary.
    int m_val, m_ndig, m_idx;
    bit m_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_ndig = 0; m_idx = 0; m_bad = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] b, output bit e_err, output bit e_fd,
                              output bit e_load, output int e_data, output int e_idx,
                              output bit e_last);
        bit dig, sep, term, spc;
        int nib;
        dig  = (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
        sep  = (b == 8'd95);
        term = (b == 8'd13);
        spc  = (b == 8'd32);
        nib  = (b <= "9") ? int'(b) - 48 : int'(b | 8'h20) - 87;
        e_err = 0; e_fd = 0; e_load = 0; e_data = 0; e_idx = 0; e_last = 0;
        if (m_bad) begin
            if (sep || term) m_bad = 1'b0;
            if (term) begin e_fd = 1; m_idx = 0; end
        end else if (dig) begin
            if (m_ndig < MAXD) begin
                m_val  = (m_val * 16 + nib) % 256;
                m_ndig = m_ndig + 1;
            end else begin
                e_err = 1; m_val = 0; m_ndig = 0; m_bad = 1'b1;
            end
        end else if (sep || term) begin
            if (m_ndig > 0) begin
                e_load = 1; e_data = m_val; e_idx = m_idx; e_last = term;
                m_idx  = (m_idx + 1) % 16;
            end
            if (term) begin e_fd = 1; m_idx = 0; end
            m_val = 0; m_ndig = 0;
        end else if (!spc) begin
            e_err = 1; m_val = 0; m_ndig = 0; m_bad = 1'b1;
        end
    endtask

    // Called in the low clock phase; returns at a negedge.
    task automatic send_byte(input logic [7:0] b);
        bit e_err, e_fd, e_load, e_last;
        int e_data, e_idx, budget;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 50) begin
            if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
            bus.in_valid = 1'b0;
            return;
        end
        model_step(b, e_err, e_fd, e_load, e_data, e_idx, e_last);
        @(posedge clk);
        #1;
        check("err",        bus.err,        e_err);
        check("frame_done", bus.frame_done, e_fd);
        check("out_valid",  bus.out_valid,  e_load);
        check("in_ready",   bus.in_ready,   !e_load);
        if (e_load) begin
            check("out_data", bus.out_data, e_data);
            check("out_idx",  bus.out_idx,  e_idx);
            check("out_last", bus.out_last, e_last);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check("err_one_cycle", bus.err,        1'b0);
        check("fd_one_cycle",  bus.frame_done, 1'b0);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string digs;
        logic [7:0] rb;
        int r;
        digs = "0123456789abcdefABCDEF";
        bus.in_data   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready,   1'b0);
        check("rst_out_valid", bus.out_valid,  1'b0);
        check("rst_err",       bus.err,        1'b0);
        check("rst_fd",        bus.frame_done, 1'b0);
        check("rst_out_data",  bus.out_data,   8'h00);
        check("rst_out_idx",   bus.out_idx,    4'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_release", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("ready_first_edge", bus.in_ready, 1'b1);
        @(negedge clk);

        // "3F_" held until out_ready
        send_str("3F_");
        repeat (2) begin
            @(posedge clk); #1;
            check("hold3f_valid", bus.out_valid, 1'b1);
            check("hold3f_data",  bus.out_data,  8'h3F);
            check("hold3f_ready", bus.in_ready,  1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain3f_valid", bus.out_valid, 1'b0);
        check("drain3f_ready", bus.in_ready,  1'b1);
        @(negedge clk);

        // Frame with terminator, then next frame restarts at index 0
        send_str("1_a2");
        send_byte(8'd13);
        send_str("7_");

        // Overflow
        send_str("123_7_");

        // Hold for five cycles
        bus.out_ready = 1'b0;
        send_str("5_");
        repeat (4) begin
            @(posedge clk); #1;
            check("hold5_valid", bus.out_valid, 1'b1);
            check("hold5_data",  bus.out_data,  8'h05);
            check("hold5_idx",   bus.out_idx,   4'h2);
            check("hold5_ready", bus.in_ready,  1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain5_valid", bus.out_valid, 1'b0);
        check("drain5_ready", bus.in_ready,  1'b1);
        @(negedge clk);

        // Illegal char, empty separators, index wrap
        send_str("G4_");
        send_str("__");
        for (int i = 0; i <= 16; i++) send_str($sformatf("%0h_", i));
        send_byte(8'd13);

        // Reset mid-token
        send_str("4");
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid,  1'b0);
        check("midrst_ready", bus.in_ready,   1'b0);
        check("midrst_err",   bus.err,        1'b0);
        check("midrst_fd",    bus.frame_done, 1'b0);
        check("midrst_data",  bus.out_data,   8'h00);
        check("midrst_last",  bus.out_last,   1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready_back", bus.in_ready, 1'b1);
        @(negedge clk);
        send_str("9_");

        // Randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      rb = digs[$urandom_range(0, 21)];
            else if (r <= 5) rb = 8'd95;
            else if (r == 6) rb = 8'd13;
            else if (r == 7) rb = 8'd32;
            else             rb = 8'($urandom_range(0, 255));
            send_byte(rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
